// File: rtl/video_bus_arbiter.sv
// video_bus_arbiter
//   Arbitrates NREQ write requesters onto a single registered video bus.
//   Requesters are served round-robin. The owner of a grant keeps the bus
//   for up to BURST consecutive writes. Frame-buffer writes (addr bit 20 set)
//   can be held back until vertical blanking.
//
// Ports
//   clk_sys        in   system clock, rising edge
//   reset_sys_n    in   asynchronous active-low reset
//   req_valid      in   [NREQ]       per-requester write request
//   req_ready      out  [NREQ]       per-requester grant (combinational)
//   req_addr       in   [NREQ][21]   per-requester video word address
//   req_data       in   [NREQ][32]   per-requester write data
//   vblank         in   1 while the raster is outside the visible area
//   fb_defer_en    in   1 holds frame-buffer writes until blanking
//   video_cs       out  bus chip select (registered)
//   video_wr       out  bus write strobe (registered)
//   video_addr     out  [21] bus word address (registered)
//   video_wr_data  out  [32] bus write data (registered)
//   grant_id       out  [2] index of the last granted requester (registered)

module video_bus_arbiter #(
  parameter int NREQ  = 3,   // 2..4
  parameter int BURST = 4    // 1..15
) (
  input  logic                   clk_sys,
  input  logic                   reset_sys_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0][20:0]  req_addr,
  input  logic [NREQ-1:0][31:0]  req_data,
  input  logic                   vblank,
  input  logic                   fb_defer_en,
  output logic                   video_cs,
  output logic                   video_wr,
  output logic [20:0]            video_addr,
  output logic [31:0]            video_wr_data,
  output logic [1:0]             grant_id
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(BURST);
  localparam logic [2:0] NREQ_W    = 3'(NREQ);

  state_e      state_q,     state_d;
  logic [1:0]  rr_ptr_q,    rr_ptr_d;
  logic [1:0]  owner_q,     owner_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;

  logic        video_cs_q,      video_cs_d;
  logic        video_wr_q,      video_wr_d;
  logic [20:0] video_addr_q,    video_addr_d;
  logic [31:0] video_wr_data_q, video_wr_data_d;
  logic [1:0]  grant_id_q,      grant_id_d;

  logic [NREQ-1:0] elig;
  logic [3:0]      elig_ext;     // padded to 4 so 2-bit indices are always in range
  logic            keep_owner;
  logic [1:0]      search_start;
  logic [2:0]      idx;
  logic            found;
  logic [1:0]      pick;
  logic            grant_any;
  logic [1:0]      grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic            transfer;
  logic [20:0]     sel_addr;
  logic [31:0]     sel_data;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    if ({1'b0, p} == NREQ_W - 3'd1) return 2'd0;
    return p + 2'd1;
  endfunction

  // A frame-buffer write is held back only while deferral is on and the
  // raster is visible; slot-register writes (bit 20 clear) always pass.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] & ~(fb_defer_en & req_addr[i][20] & ~vblank);
    end
  end

  assign elig_ext = 4'(elig);

  // The owner keeps the bus while it is eligible and has burst budget left.
  // Otherwise a round-robin search runs. In HOLD it starts just past the
  // owner, which is the rr_ptr value that HOLD exit loads. The search wraps,
  // so an exhausted owner that is the only eligible requester is regranted
  // as a fresh burst.
  always_comb begin
    keep_owner   = (state_q == ST_HOLD) && elig_ext[owner_q] &&
                   (burst_cnt_q < BURST_MAX);
    search_start = (state_q == ST_HOLD) ? wrap_inc(owner_q) : rr_ptr_q;
    found        = 1'b0;
    pick         = search_start;
    idx          = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, search_start} + 3'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && elig_ext[idx[1:0]]) begin
        found = 1'b1;
        pick  = idx[1:0];
      end
    end
    if (keep_owner) begin
      grant_any = 1'b1;
      grant_idx = owner_q;
    end else begin
      grant_any = found;
      grant_idx = pick;
    end
  end

  // Grants are gated by reset so req_ready is 0 while reset is held.
  always_comb begin
    grant_oh = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_any && reset_sys_n && (grant_idx == 2'(i))) begin
        grant_oh[i] = 1'b1;
        sel_addr    = req_addr[i];
        sel_data    = req_data[i];
      end
    end
  end

  assign req_ready = grant_oh;
  assign transfer  = |grant_oh;   // a grant only goes to a valid requester

  // Arbitration state
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (keep_owner) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + 4'd1;
    end else begin
      if (state_q == ST_HOLD) rr_ptr_d = search_start;
      if (found) begin
        state_d     = ST_HOLD;
        owner_d     = pick;
        burst_cnt_d = 4'd1;
      end else begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    end
  end

  // Bus register inputs: strobes follow the transfer, data fields hold when idle.
  always_comb begin
    video_cs_d      = transfer;
    video_wr_d      = transfer;
    video_addr_d    = video_addr_q;
    video_wr_data_d = video_wr_data_q;
    grant_id_d      = grant_id_q;
    if (transfer) begin
      video_addr_d    = sel_addr;
      video_wr_data_d = sel_data;
      grant_id_d      = grant_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      owner_q         <= '0;
      burst_cnt_q     <= '0;
      video_cs_q      <= 1'b0;
      video_wr_q      <= 1'b0;
      video_addr_q    <= '0;
      video_wr_data_q <= '0;
      grant_id_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      owner_q         <= owner_d;
      burst_cnt_q     <= burst_cnt_d;
      video_cs_q      <= video_cs_d;
      video_wr_q      <= video_wr_d;
      video_addr_q    <= video_addr_d;
      video_wr_data_q <= video_wr_data_d;
      grant_id_q      <= grant_id_d;
    end
  end

  assign video_cs      = video_cs_q;
  assign video_wr      = video_wr_q;
  assign video_addr    = video_addr_q;
  assign video_wr_data = video_wr_data_q;
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Self-checking bench for video_bus_arbiter (NREQ=3, BURST=4).
// A behavioural model tracks who owns the bus, how many writes are left in
// the burst and where the round-robin search starts. It predicts req_ready
// each cycle and the registered bus one cycle later.

module tb_video_bus_arbiter;

  localparam int NREQ  = 3;
  localparam int BURST = 4;

  logic                  clk_sys = 1'b0;
  logic                  reset_sys_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][20:0] req_addr;
  logic [NREQ-1:0][31:0] req_data;
  logic                  vblank;
  logic                  fb_defer_en;
  logic                  video_cs;
  logic                  video_wr;
  logic [20:0]           video_addr;
  logic [31:0]           video_wr_data;
  logic [1:0]            grant_id;

  video_bus_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (
    .clk_sys       (clk_sys),
    .reset_sys_n   (reset_sys_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .vblank        (vblank),
    .fb_defer_en   (fb_defer_en),
    .video_cs      (video_cs),
    .video_wr      (video_wr),
    .video_addr    (video_addr),
    .video_wr_data (video_wr_data),
    .grant_id      (grant_id)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_hold;     // a requester currently owns a burst
  int          m_owner;
  int          m_cnt;      // writes done in the current burst
  int          m_rr;       // round-robin start used when nobody owns the bus
  int          m_grant;    // -1 when nobody is granted this cycle
  bit          m_cont;     // this cycle's grant extends the current burst
  logic        e_cs, e_wr;
  logic [1:0]  e_gid;
  logic [20:0] e_addr;
  logic [31:0] e_data;

  function automatic logic [NREQ-1:0] model_elig();
    logic [NREQ-1:0] e;
    for (int i = 0; i < NREQ; i++) begin
      bit deferred;
      deferred = fb_defer_en && req_addr[i][20] && !vblank;
      e[i] = req_valid[i] && !deferred;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_owner = 0; m_cnt = 0; m_rr = 0; m_grant = -1; m_cont = 0;
    e_cs = 0; e_wr = 0; e_gid = '0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_arbitrate();
    logic [NREQ-1:0] e;
    int start;
    e = model_elig();
    m_cont = m_hold && e[m_owner[1:0]] && (m_cnt < BURST);
    if (m_cont) begin
      m_grant = m_owner;
    end else begin
      start   = m_hold ? (m_owner + 1) % NREQ : m_rr;
      m_grant = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (start + k) % NREQ;
        if (m_grant < 0 && e[j[1:0]]) m_grant = j;
      end
    end
  endtask

  task automatic model_clock();
    if (m_grant >= 0) begin
      e_cs = 1; e_wr = 1; e_gid = m_grant[1:0];
      e_addr = req_addr[m_grant[1:0]];
      e_data = req_data[m_grant[1:0]];
    end else begin
      e_cs = 0; e_wr = 0;
    end
    if (m_cont) begin
      m_cnt++;
    end else begin
      if (m_hold) m_rr = (m_owner + 1) % NREQ;
      if (m_grant >= 0) begin
        m_hold = 1; m_owner = m_grant; m_cnt = 1;
      end else begin
        m_hold = 0;
      end
    end
  endtask

  function automatic logic [63:0] bus_obs();
    return 64'({video_cs, video_wr, grant_id, video_addr, video_wr_data});
  endfunction

  function automatic logic [63:0] bus_exp();
    return 64'({e_cs, e_wr, e_gid, e_addr, e_data});
  endfunction

  // One clock cycle. Entered just after a rising edge with inputs already
  // driven: check ready before the edge, then the bus just after it.
  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    #1;
    model_arbitrate();
    exp_ready = (m_grant >= 0) ? NREQ'(1 << m_grant) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk_sys);
    model_clock();
    #1;
    check("bus", bus_obs(), bus_exp());
  endtask

  task automatic peek_ready(input string tag, input logic [NREQ-1:0] exp);
    #1;
    check(tag, 64'(req_ready), 64'(exp));
  endtask

  initial begin
    reset_sys_n = 1'b0;
    req_valid   = '1;
    req_addr    = '0;
    req_data    = '0;
    vblank      = 1'b0;
    fb_defer_en = 1'b0;
    model_reset();

    // Reset state, including ready held low with requests pending
    #3;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_bus", bus_obs(), 64'(0));
    @(posedge clk_sys); #1;
    check("rst_bus_edge", bus_obs(), 64'(0));
    @(posedge clk_sys); #1;
    reset_sys_n = 1'b1;

    // All three continuously valid: bursts of four in order 0,1,2,...
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = 21'($urandom);
        req_data[i] = $urandom;
      end
      cycle();
      check("seq_gid", 64'(grant_id), 64'((n / 4) % 3));
      check("seq_cs", 64'(video_cs), 64'(1));
    end

    // Single one-cycle request from requester 1
    req_valid = '0;
    cycle();
    req_valid   = 3'b010;
    req_addr[1] = 21'h000400;
    req_data[1] = 32'hDEAD_BEEF;
    cycle();
    check("single_bus", bus_obs(), 64'({1'b1, 1'b1, 2'd1, 21'h000400, 32'hDEADBEEF}));
    req_valid = '0;
    cycle();
    check("single_cs_drop", 64'({video_cs, video_wr}), 64'(0));
    check("single_addr_hold", 64'(video_addr), 64'(21'h000400));

    // Deferral: frame-buffer req 0 waits, slot-register req 2 proceeds
    fb_defer_en = 1'b1;
    vblank      = 1'b0;
    req_addr[0] = 21'h100010;
    req_addr[2] = 21'h000C00;
    req_valid   = 3'b101;
    for (int n = 0; n < 6; n++) begin
      peek_ready("defer_only2", 3'b100);
      cycle();
    end
    req_valid = 3'b001;
    vblank    = 1'b1;
    peek_ready("defer_vblank_rise", 3'b001);
    cycle();

    // Long deferral: 1000 visible cycles, then serviced on the vblank rise
    vblank = 1'b0;
    for (int n = 0; n < 1000; n++) cycle();
    vblank = 1'b1;
    peek_ready("long_defer_rise", 3'b001);
    cycle();

    // Owner drops mid-burst: next requester takes over with no bubble
    fb_defer_en = 1'b0;
    req_valid   = '0;
    cycle();
    req_valid = 3'b001;
    cycle();
    cycle();
    req_valid = 3'b010;
    peek_ready("handover_ready", 3'b010);
    cycle();
    check("handover_bus", 64'({video_cs, grant_id}), 64'({1'b1, 2'd1}));

    // Reset pulse during a requester 2 burst
    req_valid = 3'b100;
    cycle();
    cycle();
    #2;
    reset_sys_n = 1'b0;
    #1;
    model_reset();
    check("midrst_ready", 64'(req_ready), 64'(0));
    check("midrst_bus", bus_obs(), 64'(0));
    @(posedge clk_sys); #1;
    check("midrst_bus_edge", bus_obs(), 64'(0));
    reset_sys_n = 1'b1;
    req_valid   = 3'b110;
    peek_ready("post_rst_rr0", 3'b010);
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
        req_addr[i] = {1'($urandom_range(1)), 20'($urandom)};
        req_data[i] = $urandom;
      end
      if ($urandom_range(15) == 0) vblank = ~vblank;
      if ($urandom_range(31) == 0) fb_defer_en = ~fb_defer_en;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
